pec_channel_arbiter: RTL
========================

Name: pec_channel_arbiter

Overview:
- Shares one SMBus CRC-8 (PEC) compute engine among NUM_CH requesters, e.g. master TX path and slave RX path.
- Keeps a private CRC context per channel and grants the engine round-robin.
- Runs each channel's clear / accumulate / generate / check operations and returns per-channel PEC results.
- Sits between the byte-level SMBus shift engines and the APB register block.

Parameters:
- NUM_CH, 2, number of requesting channels (2..4)
- CRC_INIT, 8'h00, context value after clear, GEN, CHECK, disable or reset
- CRC_POLY, 8'h07, CRC-8 polynomial x^8+x^2+x+1

Ports:
- i_sys_clk  in  1  system clock
- i_rst  in  1  synchronous active-high reset
- i_pec_en  in  1  global PEC enable
- i_req_valid  in  NUM_CH  per-channel request valid
- o_req_ready  out  NUM_CH  per-channel grant; request accepted on valid&ready
- i_req_op  in  2*NUM_CH  per-channel op: 00 CLEAR, 01 DATA, 10 GEN, 11 CHECK
- i_req_data  in  8*NUM_CH  per-channel data byte (DATA: payload; CHECK: received PEC)
- o_rsp_valid  out  NUM_CH  one-cycle response pulse (GEN/CHECK only)
- o_rsp_pec  out  8*NUM_CH  per-channel PEC result, held until that channel's next response
- o_rsp_error  out  NUM_CH  CHECK mismatch flag, held until that channel's next response
- o_busy  out  1  engine occupied

Behaviour:
- Single clock domain; i_rst synchronous, active-high.
- Reset values:
  - All contexts = CRC_INIT.
  - o_req_ready = 0, o_rsp_valid = 0, o_rsp_pec = 0, o_rsp_error = 0, o_busy = 0.
  - Round-robin pointer: channel 0 highest priority.
- CRC step: crc ^= data, then 8 iterations of crc = crc[7] ? (crc<<1)^CRC_POLY : crc<<1 (MSB first, SMBus standard).
- Arbitration:
  - o_req_ready is combinational: one-hot to the highest-priority valid channel, only when engine idle and i_pec_en=1.
  - After a grant, the served channel becomes lowest priority.
  - A channel not granted holds its request stable.
- FSM states: IDLE, EXEC (bit-serial only), RESP.
- Operations, all taking effect on the acceptance edge E0:
  - CLEAR: context = CRC_INIT; no response.
  - DATA: context = step(context, data); no response.
  - GEN: o_rsp_pec = context, o_rsp_error = 0, context = CRC_INIT; o_rsp_valid high the cycle after E0.
  - CHECK: o_rsp_pec = context (pre-update), o_rsp_error = (context != data), context = CRC_INIT; o_rsp_valid high the cycle after E0.
- Throughput (byte-parallel): one accepted request per cycle; back-to-back grants allowed, including the same channel if it is the only requester.
- o_busy: high while FSM is not IDLE.
- i_pec_en = 0:
  - o_req_ready = 0.
  - All contexts reset to CRC_INIT at next edge.
  - In-flight operation aborted with no response.
  - o_rsp_pec and o_rsp_error retain their values.
- Reset mid-operation behaves the same as disable, except outputs return to reset values.
- Simultaneous valid on all channels: exactly one grant per acceptance; order follows round-robin rotation.
- Ignored conditions:
  - i_req_op/i_req_data of non-granted channels.
  - Any valid while o_req_ready = 0.

Optional Feature:
- Macro: PEC_BITSERIAL_EN.
- Defined: DATA ops use a bit-serial engine, one CRC iteration per cycle.
  - E0 loads the shift register; FSM goes to EXEC.
  - A 3-bit counter runs edges E1..E8; the context is written at E8.
  - o_req_ready = 0 and o_busy = 1 from E0 through E8; next acceptance earliest at E9.
  - CLEAR/GEN/CHECK remain single-cycle.
  - i_pec_en drop or reset during EXEC aborts and clears the counter.
- Undefined: single-cycle combinational 8-iteration step; no EXEC state.

Test Plan:
- ch0 CLEAR, DATA 0x01, GEN -> o_rsp_valid[0] pulses once; o_rsp_pec[0] = 0x07; context back to 0x00.
- ch0 DATA "123456789" (0x31..0x39), then CHECK 0xF4 -> o_rsp_error[0] = 0, pec = 0xF4; repeat with CHECK 0xF5 -> error = 1.
- ch0 and ch1 interleaved: ch0 DATA 0x01,0x01; ch1 DATA 0x80 -> ch0 GEN = 0x12, ch1 GEN = 0x89; contexts independent.
- Both channels valid continuously for 6 requests -> grants alternate 0,1,0,1,0,1; no starvation; exactly one ready per cycle.
- Drop i_pec_en mid-sequence, then re-enable and GEN ch0 -> pec = 0x00; no response during disable; with PEC_BITSERIAL_EN, drop at E4 -> no context write, o_busy low next cycle.
- With PEC_BITSERIAL_EN: DATA 0x80 accepted at E0 -> ready low E0..E8, context = 0x89 after E8, next accept at E9; i_rst at E3 -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/pec_channel_arbiter.sv
// Round-robin arbiter that shares one SMBus CRC-8 (PEC) engine among NUM_CH channels, each with a private context.
// Define PEC_BITSERIAL_EN to run DATA ops through a one-iteration-per-cycle engine instead of the single-cycle step.
module pec_channel_arbiter #(
    parameter int         NUM_CH   = 2,
    parameter logic [7:0] CRC_INIT = 8'h00,
    parameter logic [7:0] CRC_POLY = 8'h07
) (
    input  logic                i_sys_clk,
    input  logic                i_rst,
    input  logic                i_pec_en,
    input  logic [NUM_CH-1:0]   i_req_valid,
    output logic [NUM_CH-1:0]   o_req_ready,
    input  logic [2*NUM_CH-1:0] i_req_op,
    input  logic [8*NUM_CH-1:0] i_req_data,
    output logic [NUM_CH-1:0]   o_rsp_valid,
    output logic [8*NUM_CH-1:0] o_rsp_pec,
    output logic [NUM_CH-1:0]   o_rsp_error,
    output logic                o_busy
);

    localparam int SEL_W = (NUM_CH > 2) ? 2 : 1;

    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_DATA  = 2'b01;
    localparam logic [1:0] OP_GEN   = 2'b10;
    localparam logic [1:0] OP_CHECK = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RESP = 2'd1;
`ifdef PEC_BITSERIAL_EN
    localparam logic [1:0] ST_EXEC = 2'd2;
`endif

    function automatic logic [7:0] crc_bit(input logic [7:0] c);
        return c[7] ? ({c[6:0], 1'b0} ^ CRC_POLY) : {c[6:0], 1'b0};
    endfunction

`ifndef PEC_BITSERIAL_EN
    function automatic logic [7:0] crc_byte(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int k = 0; k < 8; k++) r = crc_bit(r);
        return r;
    endfunction
`endif

    logic [7:0]          ctx [NUM_CH];
    logic [1:0]          state;
    logic [SEL_W-1:0]    ptr;
    logic [NUM_CH-1:0]   grant;
    logic [SEL_W-1:0]    gsel;
    logic [SEL_W-1:0]    cand;
    logic                found;
    logic                engine_free;
    int                  idx;
    logic [1:0]          op_sel;
    logic [7:0]          data_sel;
    logic [7:0]          ctx_sel;
    logic [NUM_CH-1:0]   rsp_valid;
    logic [NUM_CH-1:0]   rsp_error;
    logic [8*NUM_CH-1:0] rsp_pec;
`ifdef PEC_BITSERIAL_EN
    logic [7:0]          shreg;
    logic [2:0]          cnt;
    logic [SEL_W-1:0]    exec_ch;
`endif

    // Only the bit-serial EXEC state blocks acceptance; the RESP cycle can take a new request.
`ifdef PEC_BITSERIAL_EN
    assign engine_free = (state != ST_EXEC);
`else
    assign engine_free = 1'b1;
`endif

    always_comb begin
        grant = '0;
        gsel  = '0;
        cand  = '0;
        idx   = 0;
        found = 1'b0;
        if (!i_rst && i_pec_en && engine_free) begin
            for (int i = 0; i < NUM_CH; i++) begin
                idx = int'(ptr) + i;
                if (idx >= NUM_CH) idx = idx - NUM_CH;
                cand = SEL_W'(idx);
                if (!found && i_req_valid[cand]) begin
                    found       = 1'b1;
                    grant[cand] = 1'b1;
                    gsel        = cand;
                end
            end
        end
    end

    assign op_sel      = i_req_op[int'(gsel)*2 +: 2];
    assign data_sel    = i_req_data[int'(gsel)*8 +: 8];
    assign ctx_sel     = ctx[gsel];
    assign o_req_ready = grant;
    assign o_rsp_valid = rsp_valid;
    assign o_rsp_pec   = rsp_pec;
    assign o_rsp_error = rsp_error;
    assign o_busy      = (state != ST_IDLE);

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_CH; i++) ctx[i] <= CRC_INIT;
            state     <= ST_IDLE;
            ptr       <= '0;
            rsp_valid <= '0;
            rsp_error <= '0;
            rsp_pec   <= '0;
`ifdef PEC_BITSERIAL_EN
            cnt       <= '0;
            exec_ch   <= '0;
`endif
        end else if (!i_pec_en) begin
            // Disable wipes every context and aborts any in-flight op; last results stay visible.
            for (int i = 0; i < NUM_CH; i++) ctx[i] <= CRC_INIT;
            state     <= ST_IDLE;
            rsp_valid <= '0;
`ifdef PEC_BITSERIAL_EN
            cnt       <= '0;
`endif
        end else begin
            rsp_valid <= '0;
            if (state == ST_RESP) state <= ST_IDLE;
`ifdef PEC_BITSERIAL_EN
            if (state == ST_EXEC) begin
                shreg <= crc_bit(shreg);
                cnt   <= cnt + 3'd1;
                if (cnt == 3'd7) begin
                    ctx[exec_ch] <= crc_bit(shreg);
                    cnt          <= '0;
                    state        <= ST_IDLE;
                end
            end
`endif
            if (found) begin
                if (int'(gsel) == NUM_CH - 1) ptr <= '0;
                else                          ptr <= gsel + 1'b1;
                case (op_sel)
                    OP_CLEAR: begin
                        ctx[gsel] <= CRC_INIT;
                        state     <= ST_IDLE;
                    end
                    OP_DATA: begin
`ifdef PEC_BITSERIAL_EN
                        shreg   <= ctx_sel ^ data_sel;
                        exec_ch <= gsel;
                        cnt     <= '0;
                        state   <= ST_EXEC;
`else
                        ctx[gsel] <= crc_byte(ctx_sel, data_sel);
                        state     <= ST_IDLE;
`endif
                    end
                    OP_GEN: begin
                        rsp_pec[int'(gsel)*8 +: 8] <= ctx_sel;
                        rsp_error[gsel]            <= 1'b0;
                        rsp_valid[gsel]            <= 1'b1;
                        ctx[gsel]                  <= CRC_INIT;
                        state                      <= ST_RESP;
                    end
                    OP_CHECK: begin
                        rsp_pec[int'(gsel)*8 +: 8] <= ctx_sel;
                        rsp_error[gsel]            <= (ctx_sel != data_sel);
                        rsp_valid[gsel]            <= 1'b1;
                        ctx[gsel]                  <= CRC_INIT;
                        state                      <= ST_RESP;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
